vga_raster_8x8: RTL and testbench
=================================

Name: vga_raster_8x8

Overview:
- Downstream display stage of the VGA instruction unit: consumes its 64-bit 8x8 monochrome framebuffer and generates 640x480@60 Hz VGA timing plus 1-bit R/G/B.
- Each framebuffer bit drives one 80x60-pixel cell.
- Framebuffer is shadow-latched once per frame so mid-frame instruction writes never tear the image.

Parameters:
- CLK_DIV, 2, clock cycles per pixel tick; 1 gives a tick every cycle; 2 derives 25 MHz from 50 MHz.
- H_VISIBLE, 640, visible pixels per line; must be divisible by 8.
- H_FRONT, 16, horizontal front porch (ticks).
- H_SYNC, 96, hsync pulse width (ticks).
- H_BACK, 48, horizontal back porch (ticks).
- V_VISIBLE, 480, visible lines per frame; must be divisible by 8.
- V_FRONT, 10, vertical front porch (lines).
- V_SYNC, 2, vsync pulse width (lines).
- V_BACK, 33, vertical back porch (lines).
- FG_COLOR, 3'b111, {r,g,b} driven for a set bit.
- BG_COLOR, 3'b000, {r,g,b} driven for a clear bit inside the visible area.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- framebuffer  in  64  live framebuffer from VGA instruction unit; byte r = row r, bit 8r+c = column c (c=0 leftmost)
- vga_hsync  out  1  horizontal sync, active low
- vga_vsync  out  1  vertical sync, active low
- vga_r  out  1  red
- vga_g  out  1  green
- vga_b  out  1  blue
- frame_start  out  1  one-clock pulse on the tick that emits position (0,0)

Behaviour:
- Reset (reset=0, asynchronous): all counters 0; shadow=0; vga_hsync=1, vga_vsync=1, rgb=000, frame_start=0. Outputs take these values immediately, independent of clock.
- Tick generator: div counter runs 0..CLK_DIV-1; tick=1 when count==CLK_DIV-1. All other state changes only on tick clocks.
- H_TOTAL = sum of H_* parameters (800); V_TOTAL = sum of V_* parameters (525).
- Counters: h in 0..H_TOTAL-1, v in 0..V_TOTAL-1. On a tick, h increments; on wrap h->0, v increments, wrapping V_TOTAL-1 -> 0.
- Cell tracking uses no division: hsub 0..CELL_W-1 with col 0..7, and vsub 0..CELL_H-1 with row 0..7, where CELL_W=H_VISIBLE/8 and CELL_H=V_VISIBLE/8. Cell counters reset to 0 at h==0 and v==0 respectively.
- Outputs are registered. On the tick edge, outputs become f(h,v,shadow) for the pre-increment h,v, so each output is the registered value of the current position, 1 tick of latency.
- vga_hsync=0 iff H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC (656..751 at defaults).
- vga_vsync=0 iff V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC (490..491 at defaults).
- rgb: in the visible area (h<H_VISIBLE and v<V_VISIBLE), rgb = shadow[8*row+col] ? FG_COLOR : BG_COLOR. Outside the visible area rgb=000.
- Shadow load: on the tick where h==H_TOTAL-1 and v==V_TOTAL-1, shadow <= framebuffer as sampled on that clock. The new frame starting at (0,0) uses it. Framebuffer changes at any other time are invisible until the next frame boundary.
- frame_start=1 for the single clock on which outputs for (0,0) are registered; 0 otherwise.
- Reset deassertion: the first tick after release emits position (0,0) with frame_start=1. Shadow is still 0 at that point, so the first frame is all BG/black. The framebuffer is first loaded at the end of that frame.
- Reset asserted mid-line or mid-frame: counters and outputs return to reset values at once, with no partial pulse completion.

Test Plan:
- Reset: hold reset=0 with framebuffer=64'hFFFF_FFFF_FFFF_FFFF -> hsync=vsync=1, rgb=000, frame_start=0. After release, the first tick gives frame_start=1 and rgb=000 for the whole first frame.
- Line timing (CLK_DIV=1, defaults): hsync low for exactly 96 clocks, starting 656 ticks after each line start. Period is 800 clocks. rgb=000 for ticks 640..799.
- Frame timing: vsync low for exactly 1600 clocks, starting at line 490. frame_start period is 420000 clocks.
- Cell mapping: framebuffer=64'h1 loaded -> rgb=111 exactly for x 0..79, y 0..59, else 000. framebuffer=64'h8000_0000_0000_0000 -> rgb=111 only for x 560..639, y 420..479.
- Shadow / no tearing: change framebuffer from 64'h0 to 64'hFF at line 100 -> no rgb change in the current frame. The next frame lights row 0 (y 0..59, x 0..639).
- Divider and reset mid-frame: with CLK_DIV=2, outputs change only on every 2nd clock and the line period is 1600 clocks. Assert reset at h=700, v=490 -> hsync, vsync and rgb return to 1/1/000 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/vga_raster_8x8.sv
// VGA timing generator rendering a 64-bit framebuffer as an 8x8 grid of solid cells.
// The framebuffer is shadowed at each frame boundary so mid-frame writes never tear.
module vga_raster_8x8 #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter logic [2:0]  FG_COLOR  = 3'b111,
  parameter logic [2:0]  BG_COLOR  = 3'b000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] framebuffer,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_r,
  output logic        vga_g,
  output logic        vga_b,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned CELL_W  = H_VISIBLE / 8;
  localparam int unsigned CELL_H  = V_VISIBLE / 8;

  localparam int HW    = $clog2(H_TOTAL + 1);
  localparam int VW    = $clog2(V_TOTAL + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW_W  = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int CH_W  = (CELL_H > 1) ? $clog2(CELL_H) : 1;

  localparam logic [HW-1:0]    H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]    V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0]    H_VIS     = HW'(H_VISIBLE);
  localparam logic [VW-1:0]    V_VIS     = VW'(V_VISIBLE);
  localparam logic [HW-1:0]    HS_START  = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0]    HS_END    = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0]    VS_START  = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0]    VS_END    = VW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [CW_W-1:0]  CW_LAST   = CW_W'(CELL_W - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(CELL_H - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [HW-1:0]    h;
  logic [VW-1:0]    v;
  logic [CW_W-1:0]  hsub;
  logic [CH_W-1:0]  vsub;
  logic [2:0]       col;
  logic [2:0]       row;
  logic [63:0]      shadow;
  logic [2:0]       rgb;
  logic             h_vis;
  logic             v_vis;

  always_comb begin
    tick  = (div_cnt == DIV_LAST);
    h_vis = (h < H_VIS);
    v_vis = (v < V_VIS);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
    end
  end

  // Outputs register f(h, v, shadow) for the pre-increment position.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      h           <= '0;
      v           <= '0;
      hsub        <= '0;
      vsub        <= '0;
      col         <= '0;
      row         <= '0;
      shadow      <= '0;
      rgb         <= '0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && (h == '0) && (v == '0);
      if (tick) begin
        vga_hsync <= !((h >= HS_START) && (h < HS_END));
        vga_vsync <= !((v >= VS_START) && (v < VS_END));
        rgb       <= (h_vis && v_vis) ? (shadow[{row, col}] ? FG_COLOR : BG_COLOR) : '0;
        if (h == H_LAST) begin
          h    <= '0;
          hsub <= '0;
          col  <= '0;
          if (v == V_LAST) begin
            v      <= '0;
            vsub   <= '0;
            row    <= '0;
            shadow <= framebuffer;
          end else begin
            v <= v + VW'(1);
            if (v_vis) begin
              if (vsub == CH_LAST) begin
                vsub <= '0;
                row  <= row + 3'd1;
              end else begin
                vsub <= vsub + CH_W'(1);
              end
            end
          end
        end else begin
          h <= h + HW'(1);
          if (h_vis) begin
            if (hsub == CW_LAST) begin
              hsub <= '0;
              col  <= col + 3'd1;
            end else begin
              hsub <= hsub + CW_W'(1);
            end
          end
        end
      end
    end
  end

  assign vga_r = rgb[2];
  assign vga_g = rgb[1];
  assign vga_b = rgb[0];

endmodule

// File: tb/tb_vga_raster_8x8.sv
// Directed bench: reduced 24x20 raster (2x2 cells) at CLK_DIV=1 and CLK_DIV=2.
module tb_vga_raster_8x8;

  // Reduced geometry: H_TOTAL=24 (hsync low h 18..20), V_TOTAL=20 (vsync low v 17..18), frame=480 ticks.
  localparam int FRAME = 480;
  localparam int LINE  = 24;

  logic        clk = 1'b0;
  logic        rst1 = 1'b1;
  logic        rst2 = 1'b1;
  logic [63:0] fb = '1;

  logic hs1, vs1, r1, g1, b1, fs1;
  logic hs2, vs2, r2, g2, b2, fs2;

  int compared   = 0;
  int mismatched = 0;
  int t1 = 0;
  int t2 = 0;

  always #5 clk = ~clk;

  vga_raster_8x8 #(
    .CLK_DIV(1), .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(16), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .FG_COLOR(3'b111), .BG_COLOR(3'b000)
  ) dut1 (
    .clock(clk), .reset(rst1), .framebuffer(fb),
    .vga_hsync(hs1), .vga_vsync(vs1), .vga_r(r1), .vga_g(g1), .vga_b(b1),
    .frame_start(fs1)
  );

  vga_raster_8x8 #(
    .CLK_DIV(2), .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(16), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .FG_COLOR(3'b111), .BG_COLOR(3'b000)
  ) dut2 (
    .clock(clk), .reset(rst2), .framebuffer(fb),
    .vga_hsync(hs2), .vga_vsync(vs2), .vga_r(r2), .vga_g(g2), .vga_b(b2),
    .frame_start(fs2)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Position p of dut1 is registered on posedge p+1 after release.
  task automatic at1(input int fr, input int x, input int y);
    int target;
    target = fr * FRAME + y * LINE + x + 1;
    while (t1 < target) begin
      @(posedge clk);
      t1++;
    end
    #1;
  endtask

  task automatic adv2(input int n);
    while (t2 < n) begin
      @(posedge clk);
      t2++;
    end
    #1;
  endtask

  initial begin
    // Reset state with an all-ones framebuffer
    #1 rst1 = 1'b0; rst2 = 1'b0;
    #1;
    chk("rst_hsync", 32'(hs1), 32'd1);
    chk("rst_vsync", 32'(vs1), 32'd1);
    chk("rst_rgb", 32'({r1, g1, b1}), 32'd0);
    chk("rst_fs", 32'(fs1), 32'd0);
    chk("rst2_hsync", 32'(hs2), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_hsync", 32'(hs1), 32'd1);
    chk("rst_hold_rgb", 32'({r1, g1, b1}), 32'd0);
    chk("rst_hold_fs", 32'(fs1), 32'd0);

    @(negedge clk);
    rst1 = 1'b1;
    t1 = 0;

    // Frame 0: shadow still zero
    at1(0, 0, 0);
    chk("f0_fs_first_tick", 32'(fs1), 32'd1);
    chk("f0_rgb_00", 32'({r1, g1, b1}), 32'd0);
    at1(0, 1, 0);
    chk("f0_fs_pulse_end", 32'(fs1), 32'd0);
    at1(0, 17, 0);
    chk("hs_before", 32'(hs1), 32'd1);
    at1(0, 18, 0);
    chk("hs_start", 32'(hs1), 32'd0);
    at1(0, 20, 0);
    chk("hs_last", 32'(hs1), 32'd0);
    at1(0, 21, 0);
    chk("hs_after", 32'(hs1), 32'd1);
    at1(0, 4, 3);
    chk("f0_rgb_black", 32'({r1, g1, b1}), 32'd0);
    fb = 64'h1;
    at1(0, 0, 16);
    chk("vs_before", 32'(vs1), 32'd1);
    at1(0, 0, 17);
    chk("vs_start", 32'(vs1), 32'd0);
    at1(0, 23, 18);
    chk("vs_last", 32'(vs1), 32'd0);
    at1(0, 0, 19);
    chk("vs_after", 32'(vs1), 32'd1);

    // Frame 1: shadow = 64'h1 lights cell (0,0) = x 0..1, y 0..1
    at1(1, 0, 0);
    chk("f1_fs", 32'(fs1), 32'd1);
    chk("f1_rgb_00", 32'({r1, g1, b1}), 32'd7);
    at1(1, 1, 0);
    chk("f1_rgb_10", 32'({r1, g1, b1}), 32'd7);
    at1(1, 2, 0);
    chk("f1_rgb_20", 32'({r1, g1, b1}), 32'd0);
    at1(1, 16, 0);
    chk("f1_rgb_hblank", 32'({r1, g1, b1}), 32'd0);
    at1(1, 0, 1);
    chk("f1_rgb_01", 32'({r1, g1, b1}), 32'd7);
    fb = 64'h8000_0000_0000_0000;
    at1(1, 1, 1);
    chk("f1_notear_11", 32'({r1, g1, b1}), 32'd7);
    at1(1, 0, 2);
    chk("f1_rgb_02", 32'({r1, g1, b1}), 32'd0);
    at1(1, 14, 15);
    chk("f1_notear_1415", 32'({r1, g1, b1}), 32'd0);

    // Frame 2: bit 63 lights x 14..15, y 14..15
    at1(2, 0, 0);
    chk("f2_fs", 32'(fs1), 32'd1);
    chk("f2_rgb_00", 32'({r1, g1, b1}), 32'd0);
    fb = 64'hFF;
    at1(2, 3, 1);
    chk("f2_notear_row0", 32'({r1, g1, b1}), 32'd0);
    at1(2, 14, 13);
    chk("f2_rgb_1413", 32'({r1, g1, b1}), 32'd0);
    at1(2, 14, 14);
    chk("f2_rgb_1414", 32'({r1, g1, b1}), 32'd7);
    at1(2, 13, 15);
    chk("f2_rgb_1315", 32'({r1, g1, b1}), 32'd0);
    at1(2, 15, 15);
    chk("f2_rgb_1515", 32'({r1, g1, b1}), 32'd7);

    // Frame 3: 64'hFF lights row 0 (y 0..1, all visible x)
    at1(3, 0, 0);
    chk("f3_rgb_00", 32'({r1, g1, b1}), 32'd7);
    at1(3, 15, 1);
    chk("f3_rgb_151", 32'({r1, g1, b1}), 32'd7);
    at1(3, 16, 1);
    chk("f3_rgb_161", 32'({r1, g1, b1}), 32'd0);
    at1(3, 0, 2);
    chk("f3_rgb_02", 32'({r1, g1, b1}), 32'd0);

    // Mid-frame async reset while rgb is lit
    at1(4, 9, 1);
    chk("f4_rgb_lit", 32'({r1, g1, b1}), 32'd7);
    #2 rst1 = 1'b0;
    #1;
    chk("midrst_rgb", 32'({r1, g1, b1}), 32'd0);
    chk("midrst_hsync", 32'(hs1), 32'd1);
    chk("midrst_fs", 32'(fs1), 32'd0);

    // CLK_DIV=2: position p registered on posedge 2(p+1)
    @(negedge clk);
    rst2 = 1'b1;
    t2 = 0;
    adv2(1);
    chk("d2_no_tick_fs", 32'(fs2), 32'd0);
    adv2(2);
    chk("d2_fs", 32'(fs2), 32'd1);
    adv2(3);
    chk("d2_fs_one_clock", 32'(fs2), 32'd0);
    adv2(37);
    chk("d2_hs_before", 32'(hs2), 32'd1);
    adv2(38);
    chk("d2_hs_start", 32'(hs2), 32'd0);
    adv2(39);
    chk("d2_hs_hold", 32'(hs2), 32'd0);
    adv2(85);
    chk("d2_hs_line2_before", 32'(hs2), 32'd1);
    adv2(86);
    chk("d2_hs_line2_start", 32'(hs2), 32'd0);
    // h=19, v=17: both syncs low
    adv2(856);
    chk("d2_pre_hsync", 32'(hs2), 32'd0);
    chk("d2_pre_vsync", 32'(vs2), 32'd0);
    #2 rst2 = 1'b0;
    #1;
    chk("d2_midrst_hsync", 32'(hs2), 32'd1);
    chk("d2_midrst_vsync", 32'(vs2), 32'd1);
    chk("d2_midrst_rgb", 32'({r2, g2, b2}), 32'd0);
    chk("d2_midrst_fs", 32'(fs2), 32'd0);
    @(negedge clk);
    rst2 = 1'b1;
    t2 = 0;
    adv2(2);
    chk("d2_rerelease_fs", 32'(fs2), 32'd1);
    chk("d2_rerelease_rgb", 32'({r2, g2, b2}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
